// File: rtl/gol_display_pkg.sv
// Shared constants for the Game-of-Life LED-matrix display controller:
// register window offsets, CTRL/STATUS bit positions and the offset decoder.
package gol_display_pkg;

    localparam logic [7:0] ROW_BASE_OFF  = 8'h00;
    localparam logic [7:0] CTRL_OFF      = 8'h80;

    localparam int CTRL_SWAP_BIT = 0;
    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_FCNT_LSB = 8;

    // Kind of register addressed by a window offset
    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_ROW,
        ACC_CTRL
    } acc_kind_e;

    // Classify a byte offset inside the 256-byte window (byte lanes ignored)
    function automatic acc_kind_e decode_offset(input logic [7:0] off);
        acc_kind_e kind;
        kind = ACC_NONE;
        if (off[7] == ROW_BASE_OFF[7]) begin
            kind = ACC_ROW;
        end else if (off[7:2] == CTRL_OFF[7:2]) begin
            kind = ACC_CTRL;
        end
        return kind;
    endfunction

endpackage

// File: rtl/gol_display_scan.sv
// Row-scan timer: a prescaler that holds each row for SCAN_DIV cycles and a
// row counter that walks 0..ROWS-1. frame_last flags the final cycle of a frame.
module gol_scan_timer
    import gol_display_pkg::*;
#(
    parameter int ROWS     = 32,
    parameter int SCAN_DIV = 1000,
    parameter int ROW_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    output logic [ROW_W-1:0] row,
    output logic             frame_last
);

    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [PRE_W-1:0] prescaler_reg;
    logic [ROW_W-1:0] row_reg;
    logic             pre_last;
    logic             row_last;

    assign pre_last   = (prescaler_reg == PRE_W'(SCAN_DIV - 1));
    assign row_last   = (row_reg == ROW_W'(ROWS - 1));
    assign frame_last = pre_last && row_last;
    assign row        = row_reg;

    // Advance the prescaler every cycle and the row on prescaler wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_reg <= '0;
            row_reg       <= '0;
        end else if (pre_last) begin
            prescaler_reg <= '0;
            row_reg       <= row_last ? '0 : row_reg + ROW_W'(1);
        end else begin
            prescaler_reg <= prescaler_reg + PRE_W'(1);
        end
    end

endmodule

// File: rtl/gol_display.sv
// Double-buffered LED-matrix controller on the CPU data bus. Stores land in
// the back bank, loads read the back bank or STATUS, and the front bank is
// scanned row by row. A requested swap waits for the frame boundary so the
// displayed generation never tears.
module gol_display
    import gol_display_pkg::*;
#(
    parameter int          ROWS      = 32,
    parameter int          SCAN_DIV  = 1000,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_write,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     write_data,
    output logic            hit,
    output logic [31:0]     rdata,
    output logic [ROWS-1:0] row_sel,
    output logic [31:0]     col_data,
    output logic            frame_end
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [31:0]      bank_reg [2][ROWS];
    logic             front_reg;
    logic             back_idx;
    logic             swap_pending_reg;
    logic [7:0]       frame_cnt_reg;
    logic [ROWS-1:0]  row_sel_reg;
    logic [31:0]      col_data_reg;
    logic             frame_end_reg;

    logic [ROW_W-1:0] scan_row;
    logic             frame_last;
    logic [ROWS-1:0]  row_onehot;

    acc_kind_e        acc_kind;
    logic [4:0]       bus_row;
    logic [ROW_W-1:0] bus_row_idx;
    logic             bus_row_valid;
    logic             row_wr;
    logic             swap_req;
    logic             addr_unused;

    gol_scan_timer #(
        .ROWS     (ROWS),
        .SCAN_DIV (SCAN_DIV),
        .ROW_W    (ROW_W)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .row        (scan_row),
        .frame_last (frame_last)
    );

    // Bus decode: byte lanes are don't-care, rows beyond ROWS are holes
    assign hit           = (alu_result[31:8] == BASE_ADDR[31:8]);
    assign acc_kind      = decode_offset(alu_result[7:0]);
    assign bus_row       = alu_result[6:2];
    assign bus_row_idx   = bus_row[ROW_W-1:0];
    assign bus_row_valid = ({27'b0, bus_row} < 32'(ROWS));
    assign back_idx      = ~front_reg;
    assign row_wr        = mem_write && hit && (acc_kind == ACC_ROW) && bus_row_valid;
    assign swap_req      = mem_write && hit && (acc_kind == ACC_CTRL) && write_data[CTRL_SWAP_BIT];
    assign addr_unused   = &{1'b0, alu_result[1:0]};

    // One-hot row select derived from the scan row
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_onehot
            assign row_onehot[gi] = (scan_row == ROW_W'(gi));
        end
    endgenerate

    // Zero-latency load data: back-bank row word or STATUS
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (acc_kind)
                ACC_ROW: begin
                    if (bus_row_valid) begin
                        rdata = bank_reg[back_idx][bus_row_idx];
                    end
                end
                ACC_CTRL: begin
                    rdata[STAT_PEND_BIT]         = swap_pending_reg;
                    rdata[STAT_FCNT_LSB +: 8]    = frame_cnt_reg;
                end
                default: rdata = '0;
            endcase
        end
    end

    // Framebuffer banks: CPU stores always target the current back bank
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < ROWS; i++) begin
                    bank_reg[b][i] <= '0;
                end
            end
        end else if (row_wr) begin
            bank_reg[back_idx][bus_row_idx] <= write_data;
        end
    end

    // Swap request, deferred front toggle at the frame boundary, frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            front_reg        <= 1'b0;
            swap_pending_reg <= 1'b0;
            frame_cnt_reg    <= '0;
        end else begin
            if (frame_last && swap_pending_reg) begin
                front_reg        <= ~front_reg;
                swap_pending_reg <= 1'b0;
            end else if (swap_req) begin
                swap_pending_reg <= 1'b1;
            end
            if (frame_last) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (reset) begin
            row_sel_reg   <= '0;
            col_data_reg  <= '0;
            frame_end_reg <= 1'b0;
        end else begin
            row_sel_reg   <= row_onehot;
            col_data_reg  <= bank_reg[front_reg][scan_row];
            frame_end_reg <= frame_last;
        end
    end

    assign row_sel   = row_sel_reg;
    assign col_data  = col_data_reg;
    assign frame_end = frame_end_reg;

endmodule

// File: tb/tb_gol_display.sv
// Randomized scoreboard bench for gol_display (ROWS=4, SCAN_DIV=4).
// The reference model tracks elapsed cycles since reset and derives the
// displayed row, frame boundary and frame count arithmetically.
module tb_gol_display;

    localparam int          ROWS     = 4;
    localparam int          SCAN_DIV = 4;
    localparam int          FRAME    = ROWS * SCAN_DIV;
    localparam logic [31:0] BASE     = 32'h0000_1000;
    localparam int          NCYC     = 4500;

    logic            clk;
    logic            reset;
    logic            mem_write;
    logic [31:0]     alu_result;
    logic [31:0]     write_data;
    logic            hit;
    logic [31:0]     rdata;
    logic [ROWS-1:0] row_sel;
    logic [31:0]     col_data;
    logic            frame_end;

    gol_display #(
        .ROWS      (ROWS),
        .SCAN_DIV  (SCAN_DIV),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .alu_result (alu_result),
        .write_data (write_data),
        .hit        (hit),
        .rdata      (rdata),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_end  (frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            hit;
        logic [31:0]     rdata;
        logic [ROWS-1:0] row_sel;
        logic [31:0]     col_data;
        logic            frame_end;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int unsigned     t;
    logic [31:0]     mbank [2][ROWS];
    bit              mfront;
    bit              mpend;
    logic [ROWS-1:0] m_rs;
    logic [31:0]     m_col;
    logic            m_fe;

    task automatic model_reset();
        t      = 0;
        mfront = 0;
        mpend  = 0;
        m_rs   = '0;
        m_col  = '0;
        m_fe   = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < ROWS; i++)
                mbank[b][i] = '0;
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return a[31:8] == BASE[31:8];
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        int unsigned off;
        int unsigned r;
        int unsigned fc;
        off = a & 32'hFF;
        if (!m_hit(a)) return 32'h0;
        if (off < 32'h80) begin
            r = off / 4;
            if (r < ROWS) return mbank[!mfront][r];
            return 32'h0;
        end
        if (off / 4 == 32'h20) begin
            fc = (t / FRAME) % 256;
            return (fc << 8) | (mpend ? 1 : 0);
        end
        return 32'h0;
    endfunction

    // Apply one clock edge to the model using the currently driven inputs
    task automatic model_edge();
        int unsigned p;
        int unsigned row;
        int unsigned off;
        bit          bnd;
        if (reset) begin
            model_reset();
            return;
        end
        p   = t % FRAME;
        row = p / SCAN_DIV;
        bnd = (p == FRAME - 1);
        m_rs  = ROWS'(1) << row;
        m_col = mbank[mfront][row];
        m_fe  = bnd;
        off   = alu_result & 32'hFF;
        if (mem_write && m_hit(alu_result) && off < 32'h80 && (off / 4) < ROWS)
            mbank[!mfront][off / 4] = write_data;
        if (bnd && mpend) begin
            mfront = !mfront;
            mpend  = 0;
        end else if (mem_write && m_hit(alu_result) && off >= 32'h80 && off <= 32'h83 && write_data[0]) begin
            mpend = 1;
        end
        t = t + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus generator: random bus traffic, biased toward boundary swaps
    initial begin
        int unsigned kind;
        exp_t        e;
        reset      = 1'b1;
        mem_write  = 1'b0;
        alu_result = '0;
        write_data = '0;
        @(posedge clk);
        model_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            reset      = (cyc < 2) || (cyc == 3007);
            mem_write  = 1'b0;
            write_data = $urandom;
            kind       = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: alu_result = BASE + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                3, 4: begin
                    mem_write  = 1'b1;
                    alu_result = BASE + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                end
                5: begin
                    mem_write  = 1'b1;
                    alu_result = BASE + 32'h80;
                end
                6: alu_result = BASE + 32'h80 + $urandom_range(0, 3);
                7: begin
                    mem_write  = $urandom_range(0, 1);
                    alu_result = BASE + 32'h84 + $urandom_range(0, 32'h7B);
                end
                default: begin
                    mem_write  = $urandom_range(0, 1);
                    alu_result = 32'h0000_2000 + ($urandom_range(0, 63) << 2);
                end
            endcase
            if (((t % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0) || cyc == 3000) begin
                mem_write  = 1'b1;
                alu_result = BASE + 32'h80;
                write_data = 32'h1;
            end
            if (mem_write)
                $display("cyc %0d store addr=%h data=%h reset=%0d", cyc, alu_result, write_data, reset);
            e.hit       = m_hit(alu_result);
            e.rdata     = m_rdata(alu_result);
            e.row_sel   = m_rs;
            e.col_data  = m_col;
            e.frame_end = m_fe;
            exp_q.push_back(e);
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: compare DUT outputs against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hit",       32'(hit),       32'(e.hit));
                chk("rdata",     rdata,          e.rdata);
                chk("row_sel",   32'(row_sel),   32'(e.row_sel));
                chk("col_data",  col_data,       e.col_data);
                chk("frame_end", 32'(frame_end), 32'(e.frame_end));
            end
        end
    end

endmodule

// File: doc/gol_display.md
# gol_display

Memory-mapped double-buffered LED-matrix display controller on the RISC-V data bus, alongside data RAM. It captures CPU stores into a back framebuffer and serves CPU loads from that buffer and a control/status register. It also scans the front buffer onto a row-multiplexed LED matrix. The CPU-requested buffer swap is deferred to the frame boundary so the Game-of-Life generation never tears on screen.

## Interface
- `ROWS`, 32: matrix rows, 1..32; one 32-bit word per row.
- `SCAN_DIV`, 1000: clk cycles each row is displayed, ≥2.
- `BASE_ADDR`, 32'h0000_1000: window base, 256-byte aligned.
- `clk`  in  1  system clock, same as CPU.
- `reset`  in  1  synchronous, active-high.
- `mem_write`  in  1  CPU store strobe.
- `alu_result`  in  32  CPU data address.
- `write_data`  in  32  CPU store data.
- `hit`  out  1  combinational: `alu_result` inside window; top level muxes `read_data` with it.
- `rdata`  out  32  combinational load data for the window.
- `row_sel`  out  ROWS  registered one-hot active row.
- `col_data`  out  32  registered column pattern of active row.
- `frame_end`  out  1  registered one-cycle pulse at frame boundary.

## Operation
- Decode: window when `alu_result[31:8]==BASE_ADDR[31:8]`. `alu_result[1:0]` ignored.
  - Offsets 0x00-0x7C (`addr[7]==0`): row word `r=addr[6:2]`.
  - Offset 0x80: CTRL/STATUS.
  - Other offsets: reads 0, writes ignored.
  - Rows `r>=ROWS`: read 0, writes ignored.
- Storage: two banks of ROWS×32 bits plus a `front` index bit.
- Row store (`mem_write`, row offset): writes `write_data` into bank `!front`, row r, at next clk edge.
- Row load: returns back bank (`!front`) row r.
- CTRL store with `write_data[0]=1` sets `swap_pending`. Bit0=0 does nothing. Store while pending has no effect.
- STATUS load: `{16'b0, frame_cnt[7:0], 7'b0, swap_pending}`.
- Scan: prescaler counts 0..SCAN_DIV-1. At terminal count it wraps and `row` advances 0..ROWS-1, wrapping to 0.
- Frame boundary: the cycle where prescaler==SCAN_DIV-1 and row==ROWS-1. On that edge:
  - `frame_cnt` increments (8-bit wrap).
  - `frame_end` pulses.
  - If `swap_pending` was 1 at the start of that cycle: toggle `front`, clear `swap_pending`.
- After a swap, the back bank holds the previous front image. Software rewrites all rows per generation.
- Outputs, registered every cycle from state at the edge: `row_sel <= 1<<row`, `col_data <= bank[front][row]`. The swap and the row wrap take effect together, so row 0 of the new frame shows the new image.

## Timing
- Reset, all synchronous:
  - prescaler=0, row=0, front=0, swap_pending=0, frame_cnt=0.
  - Both banks cleared to 0. Reset takes one cycle; banks are registers, not RAM.
  - `row_sel=0`, `col_data=0`, `frame_end=0`.
- First cycle after reset: `row_sel=1`, `col_data=0`.
- Reset mid-frame or with a swap pending: everything returns to reset values and the pending swap is discarded.
- `rdata` and `hit` are combinational, zero-latency, as required by the single-cycle core's loads.
- A store is visible to a load in the following cycle.
- Display latency: 1 cycle from row/prescaler state to `row_sel`/`col_data`.
- Frame period: `ROWS*SCAN_DIV` cycles. Each row is shown exactly SCAN_DIV consecutive cycles.
- CTRL store in the frame-boundary cycle itself: pending is set at that edge, and the swap happens at the next boundary.
- Row store to the back bank in the swap cycle: the write lands in the pre-swap back bank, which becomes front. That row is displayed.

## Structure
- `gol_display_pkg`:
  - Offsets `ROW_BASE_OFF=8'h00`, `CTRL_OFF=8'h80`.
  - CTRL bit `CTRL_SWAP_BIT=0`.
  - STATUS field positions `STAT_PEND_BIT=0`, `STAT_FCNT_LSB=8`.
- Sub-module `gol_scan_timer`:
  - Holds the prescaler and row counter.
  - Outputs `row` and a combinational `frame_last` (boundary-cycle flag).
- Top handles decode, banks, swap logic and output registers.

## Test plan
- Reset, ROWS=4, SCAN_DIV=4 -> `row_sel` = 0001,0010,0100,1000 for 4 cycles each; `frame_end` pulses at cycles 16, 32; STATUS read = 0x0000_0100 after first frame.
- Store row 2 = 0xA5A5_0F0F, load row 2 -> 0xA5A5_0F0F next cycle; `col_data` stays 0 during row 2 display (front unchanged).
- Store CTRL=1 mid-frame -> STATUS bit0=1 until boundary, then 0. Next frame's row 2 `col_data`=0xA5A5_0F0F; load row 2 now returns 0 (old front).
- CTRL store exactly in boundary cycle -> no swap at that boundary; swap at the following one (16 cycles later).
- Loads/stores at offset 0x84, row 5 (ROWS=4), and outside window -> `rdata`=0 or `hit`=0; no state change; `hit`=1 for 0x84, 0 outside.
- Assert reset with swap pending mid-frame -> next cycle all outputs 0 except `row_sel`=0001 after one more cycle; STATUS=0; both banks read 0.
